// File: rtl/tick_sequencer.sv
// Game-tick sequencer: divides the system clock into ticks, runs the netlist for
// STEP / RUN_N / RUN_FREE commands, latches its inputs and captures its outputs.
module tick_sequencer #(
  parameter int TICK_DIV = 4,
  parameter int CNT_W    = 32,
  parameter int IO_W     = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd_op,
  input  logic [CNT_W-1:0] i_cmd_count,
  output logic             o_cmd_ready,
  output logic             o_cmd_err,
  input  logic             i_count_clr,
  input  logic [IO_W-1:0]  i_in_data,
  output logic [IO_W-1:0]  o_circ_in,
  output logic             o_tick,
  input  logic [IO_W-1:0]  i_circ_out,
  output logic [IO_W-1:0]  o_out_data,
  output logic             o_out_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_tick_count
);

  // Command handshake: a command is taken in any cycle where i_cmd_valid and
  // o_cmd_ready are both high; o_cmd_ready is low only while reset is held.

  localparam int PH_W = $clog2(TICK_DIV);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0] PH_PRE  = PH_W'(TICK_DIV - 2);

  localparam logic [1:0] OP_STOP     = 2'd0;
  localparam logic [1:0] OP_STEP     = 2'd1;
  localparam logic [1:0] OP_RUN_FREE = 2'd3;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [PH_W-1:0]  phase;
  logic [CNT_W-1:0] remaining;
  logic             stop_pending;
  logic             free_run;

  logic             cmd_fire;
  logic             stop_cmd;
  logic             start_cmd;
  logic [CNT_W-1:0] start_count;
  logic             tick_phase;
  logic             last_tick;

  always_comb begin
    cmd_fire    = i_cmd_valid & o_cmd_ready;
    stop_cmd    = cmd_fire && (i_cmd_op == OP_STOP);
    start_cmd   = cmd_fire && (i_cmd_op != OP_STOP);
    start_count = (i_cmd_op == OP_STEP) ? CNT_W'(1) : i_cmd_count;
    tick_phase  = (state == RUN) && (phase == PH_LAST);
    // A STOP landing on the tick cycle itself ends the run at that tick.
    last_tick   = tick_phase &&
                  ((!free_run && remaining == CNT_W'(1)) || stop_pending || stop_cmd);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      phase        <= '0;
      remaining    <= '0;
      stop_pending <= 1'b0;
      free_run     <= 1'b0;
      o_circ_in    <= '0;
      o_tick       <= 1'b0;
      o_out_data   <= '0;
      o_out_valid  <= 1'b0;
      o_done       <= 1'b0;
      o_cmd_err    <= 1'b0;
      o_tick_count <= '0;
    end else begin
      o_tick      <= 1'b0;
      o_out_valid <= o_tick;
      o_done      <= 1'b0;
      o_cmd_err   <= 1'b0;

      if (o_tick) o_out_data <= i_circ_out;

      if (tick_phase)       o_tick_count <= i_count_clr ? CNT_W'(1) : o_tick_count + 1'b1;
      else if (i_count_clr) o_tick_count <= '0;

      case (state)
        IDLE: begin
          if (start_cmd) begin
            if (i_cmd_op == OP_RUN_FREE) begin
              state        <= RUN;
              phase        <= '0;
              free_run     <= 1'b1;
              remaining    <= '0;
              stop_pending <= 1'b0;
            end else if (start_count == '0) begin
              o_done <= 1'b1;
            end else begin
              state        <= RUN;
              phase        <= '0;
              free_run     <= 1'b0;
              remaining    <= start_count;
              stop_pending <= 1'b0;
            end
          end
        end
        RUN: begin
          if (phase == '0) o_circ_in <= i_in_data;
          if (start_cmd) o_cmd_err <= 1'b1;
          if (stop_cmd) stop_pending <= 1'b1;
          // o_tick is set one phase early so it is a flop aligned to PH_LAST.
          if (phase == PH_PRE) o_tick <= 1'b1;
          phase <= tick_phase ? '0 : phase + 1'b1;
          if (tick_phase && !free_run) remaining <= remaining - 1'b1;
          if (last_tick) begin
            state        <= IDLE;
            phase        <= '0;
            remaining    <= '0;
            stop_pending <= 1'b0;
            free_run     <= 1'b0;
            o_done       <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_cmd_ready = ~i_reset;
  assign o_busy      = (state == RUN);

endmodule

// File: tb/tb_tick_sequencer.sv
// Directed bench for tick_sequencer (TICK_DIV=4, CNT_W=4, IO_W=8).
module tb_tick_sequencer;
  localparam int TD = 4;
  localparam int CW = 4;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_count;
  logic          cmd_ready;
  logic          cmd_err;
  logic          count_clr;
  logic [IW-1:0] in_data;
  logic [IW-1:0] circ_in;
  logic          tick;
  logic [IW-1:0] circ_out;
  logic [IW-1:0] out_data;
  logic          out_valid;
  logic          busy;
  logic          done;
  logic [CW-1:0] tick_count;

  int checks = 0;
  int fails  = 0;
  logic [CW-1:0] exp_count = '0;

  tick_sequencer #(.TICK_DIV(TD), .CNT_W(CW), .IO_W(IW)) dut (
    .i_clk(clk), .i_reset(reset), .i_cmd_valid(cmd_valid), .i_cmd_op(cmd_op),
    .i_cmd_count(cmd_count), .o_cmd_ready(cmd_ready), .o_cmd_err(cmd_err),
    .i_count_clr(count_clr), .i_in_data(in_data), .o_circ_in(circ_in),
    .o_tick(tick), .i_circ_out(circ_out), .o_out_data(out_data),
    .o_out_valid(out_valid), .o_busy(busy), .o_done(done), .o_tick_count(tick_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge; one call = one cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [CW-1:0] cnt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_count = '0;
    count_clr = 1'b0; in_data = '0; circ_out = '0;
    next_cycle();
    next_cycle();
    checks++;
    if ({cmd_ready, cmd_err, tick, out_valid, busy, done} !== 6'b0) begin
      fails++; $display("FAIL reset_flags got=%b exp=000000", {cmd_ready, cmd_err, tick, out_valid, busy, done});
    end
    checks++;
    if ({circ_in, out_data, tick_count} !== '0) begin
      fails++; $display("FAIL reset_data circ_in=%h out_data=%h count=%0d exp all 0", circ_in, out_data, tick_count);
    end
    reset = 1'b0;
    next_cycle();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL post_reset ready=%b busy=%b exp ready=1 busy=0", cmd_ready, busy);
    end
    exp_count = '0;
  endtask

  task automatic test_run_n();
    send_cmd(2'd2, 4'd2);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      next_cycle();
      cmd_valid = 1'b0;
      checks++;
      if (busy !== (cyc >= 1 && cyc <= 8)) begin
        fails++; $display("FAIL run_n busy cyc=%0d got=%b", cyc, busy);
      end
      checks++;
      if (tick !== (cyc == 4 || cyc == 8)) begin
        fails++; $display("FAIL run_n tick cyc=%0d got=%b", cyc, tick);
      end
      checks++;
      if (out_valid !== (cyc == 5 || cyc == 9)) begin
        fails++; $display("FAIL run_n out_valid cyc=%0d got=%b", cyc, out_valid);
      end
      checks++;
      if (done !== (cyc == 9)) begin
        fails++; $display("FAIL run_n done cyc=%0d got=%b", cyc, done);
      end
    end
    exp_count = exp_count + 4'd2;
    checks++;
    if (tick_count !== exp_count) begin
      fails++; $display("FAIL run_n count got=%0d exp=%0d", tick_count, exp_count);
    end
  endtask

  task automatic test_step_io();
    in_data  = 8'hA5;
    circ_out = 8'h11;
    send_cmd(2'd1, 4'd0);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      next_cycle();
      cmd_valid = 1'b0;
      if (cyc == 2) in_data = 8'h00;
      if (cyc == 4) circ_out = 8'h3C;
      if (cyc == 5) circ_out = 8'h77;
      if (cyc >= 2 && cyc <= 4) begin
        checks++;
        if (circ_in !== 8'hA5) begin
          fails++; $display("FAIL step circ_in cyc=%0d got=%h exp=a5", cyc, circ_in);
        end
      end
      if (cyc == 5) begin
        checks++;
        if (out_data !== 8'h3C || out_valid !== 1'b1 || done !== 1'b1) begin
          fails++; $display("FAIL step capture out_data=%h ov=%b done=%b exp 3c 1 1", out_data, out_valid, done);
        end
      end
      if (cyc == 6) begin
        checks++;
        if (out_data !== 8'h3C || out_valid !== 1'b0) begin
          fails++; $display("FAIL step hold out_data=%h ov=%b exp 3c 0", out_data, out_valid);
        end
      end
    end
    exp_count = exp_count + 4'd1;
    checks++;
    if (tick_count !== exp_count) begin
      fails++; $display("FAIL step count got=%0d exp=%0d", tick_count, exp_count);
    end
  endtask

  task automatic test_free_stop();
    send_cmd(2'd3, 4'd0);
    for (int cyc = 1; cyc <= 16; cyc++) begin
      next_cycle();
      cmd_valid = 1'b0;
      if (cyc == 10) send_cmd(2'd0, 4'd0);
      checks++;
      if (tick !== (cyc == 4 || cyc == 8 || cyc == 12)) begin
        fails++; $display("FAIL free tick cyc=%0d got=%b", cyc, tick);
      end
      checks++;
      if (done !== (cyc == 13) || busy !== (cyc <= 12)) begin
        fails++; $display("FAIL free done/busy cyc=%0d done=%b busy=%b", cyc, done, busy);
      end
      checks++;
      if (cmd_err !== 1'b0) begin
        fails++; $display("FAIL free err cyc=%0d got=%b exp=0", cyc, cmd_err);
      end
    end
    exp_count = exp_count + 4'd3;
    checks++;
    if (tick_count !== exp_count) begin
      fails++; $display("FAIL free count got=%0d exp=%0d", tick_count, exp_count);
    end
  endtask

  task automatic test_zero_and_err();
    send_cmd(2'd2, 4'd0);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      next_cycle();
      cmd_valid = 1'b0;
      checks++;
      if (done !== (cyc == 1) || busy !== 1'b0 || tick !== 1'b0) begin
        fails++; $display("FAIL zero cyc=%0d done=%b busy=%b tick=%b", cyc, done, busy, tick);
      end
    end
    send_cmd(2'd2, 4'd2);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      next_cycle();
      cmd_valid = 1'b0;
      if (cyc == 2) send_cmd(2'd2, 4'd5);
      checks++;
      if (cmd_err !== (cyc == 3)) begin
        fails++; $display("FAIL err pulse cyc=%0d got=%b", cyc, cmd_err);
      end
      checks++;
      if (tick !== (cyc == 4 || cyc == 8) || done !== (cyc == 9) || busy !== (cyc <= 8)) begin
        fails++; $display("FAIL err run cyc=%0d tick=%b done=%b busy=%b", cyc, tick, done, busy);
      end
    end
    exp_count = exp_count + 4'd2;
    checks++;
    if (tick_count !== exp_count) begin
      fails++; $display("FAIL err count got=%0d exp=%0d", tick_count, exp_count);
    end
  endtask

  task automatic test_stop_on_final_tick();
    send_cmd(2'd2, 4'd1);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      next_cycle();
      cmd_valid = 1'b0;
      if (cyc == 4) send_cmd(2'd0, 4'd0);
      checks++;
      if (tick !== (cyc == 4) || done !== (cyc == 5) || busy !== (cyc <= 4) || cmd_err !== 1'b0) begin
        fails++; $display("FAIL stop_final cyc=%0d tick=%b done=%b busy=%b err=%b", cyc, tick, done, busy, cmd_err);
      end
    end
    exp_count = exp_count + 4'd1;
  endtask

  task automatic test_reset_mid_run();
    in_data  = 8'h5A;
    circ_out = 8'h3C;
    send_cmd(2'd2, 4'd3);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      next_cycle();
      cmd_valid = 1'b0;
      if (cyc == 2) begin
        checks++;
        if (circ_in !== 8'h5A || tick_count !== exp_count) begin
          fails++; $display("FAIL pre_reset circ_in=%h count=%0d exp 5a %0d", circ_in, tick_count, exp_count);
        end
      end
      if (cyc == 3) reset = 1'b1;
      if (cyc == 4) begin
        checks++;
        if ({cmd_ready, cmd_err, tick, out_valid, busy, done} !== 6'b0) begin
          fails++; $display("FAIL mid_reset flags got=%b exp=000000", {cmd_ready, cmd_err, tick, out_valid, busy, done});
        end
        checks++;
        if ({circ_in, out_data, tick_count} !== '0) begin
          fails++; $display("FAIL mid_reset data circ_in=%h out=%h count=%0d exp all 0", circ_in, out_data, tick_count);
        end
        reset = 1'b0;
      end
      if (cyc >= 5) begin
        checks++;
        if (tick !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
          fails++; $display("FAIL after_reset cyc=%0d tick=%b done=%b busy=%b exp 0", cyc, tick, done, busy);
        end
      end
    end
    exp_count = '0;
  endtask

  task automatic test_wrap_and_clr();
    int n;
    send_cmd(2'd2, 4'd15);
    next_cycle();
    cmd_valid = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 100) begin
      next_cycle();
      n++;
    end
    checks++;
    if (done !== 1'b1 || n != 61) begin
      fails++; $display("FAIL long_run done=%b cycles=%0d exp done at 61", done, n);
    end
    checks++;
    if (tick_count !== 4'd15) begin
      fails++; $display("FAIL long_run count got=%0d exp=15", tick_count);
    end
    // New command in the o_done cycle.
    send_cmd(2'd1, 4'd0);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      next_cycle();
      cmd_valid = 1'b0;
      checks++;
      if (tick !== (cyc == 4) || done !== (cyc == 5) || busy !== (cyc <= 4)) begin
        fails++; $display("FAIL back_to_back cyc=%0d tick=%b done=%b busy=%b", cyc, tick, done, busy);
      end
    end
    checks++;
    if (tick_count !== 4'd0) begin
      fails++; $display("FAIL wrap count got=%0d exp=0", tick_count);
    end
    send_cmd(2'd2, 4'd2);
    for (int cyc = 1; cyc <= 11; cyc++) begin
      next_cycle();
      cmd_valid = 1'b0;
      count_clr = (cyc == 4 || cyc == 10);
      if (cyc == 5) begin
        checks++;
        if (tick_count !== 4'd1) begin
          fails++; $display("FAIL clr_on_tick count got=%0d exp=1", tick_count);
        end
      end
      if (cyc == 9) begin
        checks++;
        if (tick_count !== 4'd2 || done !== 1'b1) begin
          fails++; $display("FAIL clr_run_end count=%0d done=%b exp 2 1", tick_count, done);
        end
      end
      if (cyc == 11) begin
        checks++;
        if (tick_count !== 4'd0) begin
          fails++; $display("FAIL clr_idle count got=%0d exp=0", tick_count);
        end
      end
    end
    count_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run_n();
    test_step_io();
    test_free_stop();
    test_zero_and_err();
    test_stop_on_final_tick();
    test_reset_mid_run();
    test_wrap_and_clr();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
